bp_me_cce_mem_arbiter: RTL and testbench

- Shares one CCE-to-memory command/response channel pair among num_cce_p CCE instances.
- Arbitrates CCE mem_cmd streams round-robin onto a single downstream mem_cmd port.
- Records each issued command's source CCE index in an in-order tag FIFO.
- Routes each in-order mem_resp back to the CCE that issued the matching command.
- Sits between the CCE wrappers and the memory/DRAM adapter in multi-CCE testbenches and tiles.

---
 rtl/bp_me_cce_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_bp_me_cce_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_cce_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bp_me_cce_mem_arbiter
//  Purpose  : Shares one CCE<->memory command/response channel pair among
//             NUM_CCE requesters. Commands are granted round-robin and passed
//             straight through. The source index of each issued command is
//             pushed into an in-order tag FIFO, and each in-order response is
//             steered back to the CCE at the FIFO head.
//  Ports    : clk_i, reset_i            clock, synchronous active-high reset
//             mem_cmd_i/_v_i/_yumi_o    per-CCE command inputs and consume
//             mem_cmd_o/_v_o/_ready_i   arbitrated downstream command
//             mem_resp_i/_v_i/_yumi_o   response from memory
//             mem_resp_o/_v_o/_ready_i  broadcast response, per-CCE valid
//             outstanding_o             tag FIFO occupancy
//             error_o                   sticky: response seen with no tag
//  Revision : 1.0  initial release
// ============================================================================
module bp_me_cce_mem_arbiter #(
    parameter int NUM_CCE         = 4,
    parameter int MEM_MSG_WIDTH   = 128,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [NUM_CCE*MEM_MSG_WIDTH-1:0]       mem_cmd_i,
    input  logic [NUM_CCE-1:0]                     mem_cmd_v_i,
    output logic [NUM_CCE-1:0]                     mem_cmd_yumi_o,
    output logic [MEM_MSG_WIDTH-1:0]               mem_cmd_o,
    output logic                                   mem_cmd_v_o,
    input  logic                                   mem_cmd_ready_i,
    input  logic [MEM_MSG_WIDTH-1:0]               mem_resp_i,
    input  logic                                   mem_resp_v_i,
    output logic                                   mem_resp_yumi_o,
    output logic [MEM_MSG_WIDTH-1:0]               mem_resp_o,
    output logic [NUM_CCE-1:0]                     mem_resp_v_o,
    input  logic [NUM_CCE-1:0]                     mem_resp_ready_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   error_o
);

    localparam int c_ID_WIDTH  = (NUM_CCE > 1) ? $clog2(NUM_CCE) : 1;
    localparam int c_CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [c_CNT_WIDTH-1:0] c_FULL_CNT = c_CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [c_PTR_WIDTH-1:0] c_PTR_LAST = c_PTR_WIDTH'(MAX_OUTSTANDING - 1);
    localparam logic [c_ID_WIDTH-1:0]  c_ID_LAST  = c_ID_WIDTH'(NUM_CCE - 1);
    localparam logic [c_ID_WIDTH:0]    c_ID_NUM   = (c_ID_WIDTH+1)'(NUM_CCE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ID_WIDTH-1:0]  r_rr_ptr;
    logic [c_PTR_WIDTH-1:0] r_wr_ptr;
    logic [c_PTR_WIDTH-1:0] r_rd_ptr;
    logic [c_CNT_WIDTH-1:0] r_count;
    logic                   r_error;
    logic [c_ID_WIDTH-1:0]  r_tag_mem [MAX_OUTSTANDING];

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [c_ID_WIDTH-1:0]  w_sel;
    logic                   w_any;
    logic [c_ID_WIDTH:0]    w_sum;
    logic [c_ID_WIDTH-1:0]  w_cand;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [c_ID_WIDTH-1:0]  w_head;
    logic [c_ID_WIDTH-1:0]  w_rr_next;

    // Round-robin search starting at r_rr_ptr; the candidate index is
    // wrapped by subtraction so non-power-of-two NUM_CCE also works.
    always_comb begin
        w_sel  = '0;
        w_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < NUM_CCE; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_ID_WIDTH+1)'(k);
            if (w_sum >= c_ID_NUM) begin
                w_sum = w_sum - c_ID_NUM;
            end
            w_cand = w_sum[c_ID_WIDTH-1:0];
            if (!w_any && mem_cmd_v_i[w_cand]) begin
                w_any = 1'b1;
                w_sel = w_cand;
            end
        end
    end

    // Full/empty come from the registered count only: a pop in the same
    // cycle does not open a slot for a push (no bypass path).
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_head  = r_tag_mem[r_rd_ptr];

    assign mem_cmd_v_o = w_any & ~w_full;
    assign mem_cmd_o   = mem_cmd_i[w_sel*MEM_MSG_WIDTH +: MEM_MSG_WIDTH];
    assign w_push      = mem_cmd_v_o & mem_cmd_ready_i;

    assign mem_resp_o      = mem_resp_i;
    assign mem_resp_yumi_o = mem_resp_v_i & ~w_empty & mem_resp_ready_i[w_head];
    assign w_pop           = mem_resp_yumi_o;

    always_comb begin
        mem_cmd_yumi_o = '0;
        mem_resp_v_o   = '0;
        for (int i = 0; i < NUM_CCE; i++) begin
            mem_cmd_yumi_o[i] = w_push & (w_sel == c_ID_WIDTH'(i));
            mem_resp_v_o[i]   = mem_resp_v_i & ~w_empty & (w_head == c_ID_WIDTH'(i));
        end
    end

    assign w_rr_next = (w_sel == c_ID_LAST) ? '0 : w_sel + 1'b1;

    assign outstanding_o = r_count;
    assign error_o       = r_error;

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= w_rr_next;
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (mem_resp_v_i && w_empty) begin
                r_error <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_me_cce_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_me_cce_mem_arbiter
//  Purpose  : Directed self-checking bench for bp_me_cce_mem_arbiter with
//             4 CCEs, 128-bit messages and 8 outstanding tags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_me_cce_mem_arbiter;

    localparam int NUM_CCE = 4;
    localparam int W       = 128;
    localparam int MAXO    = 8;
    localparam int CNTW    = $clog2(MAXO + 1);

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic [NUM_CCE*W-1:0]   mem_cmd_i;
    logic [NUM_CCE-1:0]     mem_cmd_v_i;
    logic [NUM_CCE-1:0]     mem_cmd_yumi_o;
    logic [W-1:0]           mem_cmd_o;
    logic                   mem_cmd_v_o;
    logic                   mem_cmd_ready_i;
    logic [W-1:0]           mem_resp_i;
    logic                   mem_resp_v_i;
    logic                   mem_resp_yumi_o;
    logic [W-1:0]           mem_resp_o;
    logic [NUM_CCE-1:0]     mem_resp_v_o;
    logic [NUM_CCE-1:0]     mem_resp_ready_i;
    logic [CNTW-1:0]        outstanding_o;
    logic                   error_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    bp_me_cce_mem_arbiter #(
        .NUM_CCE         (NUM_CCE),
        .MEM_MSG_WIDTH   (W),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .mem_cmd_i        (mem_cmd_i),
        .mem_cmd_v_i      (mem_cmd_v_i),
        .mem_cmd_yumi_o   (mem_cmd_yumi_o),
        .mem_cmd_o        (mem_cmd_o),
        .mem_cmd_v_o      (mem_cmd_v_o),
        .mem_cmd_ready_i  (mem_cmd_ready_i),
        .mem_resp_i       (mem_resp_i),
        .mem_resp_v_i     (mem_resp_v_i),
        .mem_resp_yumi_o  (mem_resp_yumi_o),
        .mem_resp_o       (mem_resp_o),
        .mem_resp_v_o     (mem_resp_v_o),
        .mem_resp_ready_i (mem_resp_ready_i),
        .outstanding_o    (outstanding_o),
        .error_o          (error_o)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [W-1:0] cmd_of(input int i);
        logic [W-1:0] v;
        v = W'(32'hC0DE_0000) + W'(i);
        return v;
    endfunction

    function automatic logic [NUM_CCE-1:0] oh(input int i);
        logic [NUM_CCE-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Grant one command with the given request vector; expects grant to g.
    task automatic grant(input string tag, input logic [NUM_CCE-1:0] req, input int g);
        mem_cmd_v_i = req;
        #1;
        check({tag, "_v"},    W'(mem_cmd_v_o), W'(1'b1));
        check({tag, "_yumi"}, W'(mem_cmd_yumi_o), W'(oh(g)));
        check({tag, "_data"}, mem_cmd_o, cmd_of(g));
        step();
        mem_cmd_v_i = '0;
    endtask

    // Accept one response with all CCEs ready; expects routing to h.
    task automatic respond(input string tag, input int h);
        mem_resp_v_i     = 1'b1;
        mem_resp_ready_i = '1;
        #1;
        check({tag, "_rv"},   W'(mem_resp_v_o), W'(oh(h)));
        check({tag, "_ry"},   W'(mem_resp_yumi_o), W'(1'b1));
        check({tag, "_rd"},   mem_resp_o, mem_resp_i);
        step();
        mem_resp_v_i = 1'b0;
    endtask

    int seq_a [7] = '{0, 1, 2, 3, 0, 2, 0};
    int seq_c [3] = '{3, 1, 3};
    int seq_e [7] = '{2, 3, 0, 1, 2, 3, 0};

    initial begin
        reset_i          = 1'b1;
        mem_cmd_v_i      = '0;
        mem_cmd_ready_i  = 1'b1;
        mem_resp_i       = {4{32'hA5A5_1234}};
        mem_resp_v_i     = 1'b0;
        mem_resp_ready_i = '1;
        for (int i = 0; i < NUM_CCE; i++) mem_cmd_i[i*W +: W] = cmd_of(i);
        step();
        step();
        reset_i = 1'b0;
        #1;
        check("rst_cmd_v",  W'(mem_cmd_v_o), '0);
        check("rst_yumi",   W'(mem_cmd_yumi_o), '0);
        check("rst_resp_v", W'(mem_resp_v_o), '0);
        check("rst_ryumi",  W'(mem_resp_yumi_o), '0);
        check("rst_outst",  W'(outstanding_o), '0);
        check("rst_err",    W'(error_o), '0);

        // All four request: grants rotate 0,1,2,3.
        for (int k = 0; k < 4; k++) grant($sformatf("rr%0d", k), 4'b1111, k);
        check("rr_outst", W'(outstanding_o), W'(4));

        // Skip-ahead and wrap: 0, then only 2, then {0,1} from pointer 3 -> 0.
        grant("skip0", 4'b1111, 0);
        grant("skip2", 4'b0100, 2);
        grant("wrap0", 4'b0011, 0);
        check("skip_outst", W'(outstanding_o), W'(7));
        for (int k = 0; k < 7; k++) respond($sformatf("drainA%0d", k), seq_a[k]);
        check("drainA_outst", W'(outstanding_o), '0);

        // Issue from 3,1,3 and route responses back in order.
        grant("c3a", 4'b1000, 3);
        grant("c1",  4'b0010, 1);
        grant("c3b", 4'b1000, 3);
        for (int k = 0; k < 3; k++) respond($sformatf("routeC%0d", k), seq_c[k]);
        check("routeC_outst", W'(outstanding_o), '0);

        // Fill to 8 outstanding.
        for (int k = 0; k < 8; k++) grant($sformatf("fill%0d", k), 4'b1111, k % 4);
        check("full_outst", W'(outstanding_o), W'(8));
        mem_cmd_v_i = 4'b1111;
        #1;
        check("full_block_v", W'(mem_cmd_v_o), '0);
        check("full_block_y", W'(mem_cmd_yumi_o), '0);
        // Pop with a request pending: no same-cycle bypass.
        mem_resp_v_i = 1'b1;
        #1;
        check("full_pop_rv",  W'(mem_resp_v_o), W'(4'b0001));
        check("full_pop_ry",  W'(mem_resp_yumi_o), W'(1'b1));
        check("full_nobyp_v", W'(mem_cmd_v_o), '0);
        step();
        mem_resp_v_i = 1'b0;
        #1;
        check("after_pop_outst", W'(outstanding_o), W'(7));
        check("after_pop_v",     W'(mem_cmd_v_o), W'(1'b1));
        check("after_pop_y",     W'(mem_cmd_yumi_o), W'(4'b0001));
        step();
        mem_cmd_v_i = '0;
        check("refill_outst", W'(outstanding_o), W'(8));

        // Head is CCE 1; hold its ready low for 5 cycles.
        mem_resp_v_i     = 1'b1;
        mem_resp_ready_i = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall%0d_rv", k), W'(mem_resp_v_o), W'(4'b0010));
            check($sformatf("stall%0d_ry", k), W'(mem_resp_yumi_o), '0);
            step();
            check($sformatf("stall%0d_outst", k), W'(outstanding_o), W'(8));
        end
        mem_resp_ready_i = 4'b0010;
        #1;
        check("unstall_ry", W'(mem_resp_yumi_o), W'(1'b1));
        step();
        mem_resp_v_i = 1'b0;
        check("unstall_outst", W'(outstanding_o), W'(7));
        for (int k = 0; k < 7; k++) respond($sformatf("drainE%0d", k), seq_e[k]);
        check("drainE_outst", W'(outstanding_o), '0);

        // Response with empty FIFO: not routed, sticky error.
        mem_resp_v_i = 1'b1;
        #1;
        check("empty_rv", W'(mem_resp_v_o), '0);
        check("empty_ry", W'(mem_resp_yumi_o), '0);
        step();
        mem_resp_v_i = 1'b0;
        check("err_set", W'(error_o), W'(1'b1));
        step();
        check("err_sticky", W'(error_o), W'(1'b1));

        // Reset mid-operation drops outstanding tags.
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("rst2_err",   W'(error_o), '0);
        check("rst2_outst", W'(outstanding_o), '0);
        grant("mid0", 4'b0011, 0);
        grant("mid1", 4'b0011, 1);
        check("mid_outst", W'(outstanding_o), W'(2));
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("rst3_outst", W'(outstanding_o), '0);
        mem_resp_v_i = 1'b1;
        #1;
        check("rst3_rv", W'(mem_resp_v_o), '0);
        check("rst3_ry", W'(mem_resp_yumi_o), '0);
        step();
        mem_resp_v_i = 1'b0;
        check("rst3_err", W'(error_o), W'(1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
